freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, meaning CLK frequency in Hz and gate length in CLK cycles.
REQ-002 Parameter CW, default 26, meaning gate counter width; SHALL satisfy 2^CW > CLK_HZ.
REQ-003 Parameter FW, default 24, meaning result width of FREQ.
REQ-004 CLK  input  1  system clock; all sequential logic on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset; one clock domain only.
REQ-006 START  input  1  single-shot measurement request, sampled only in IDLE.
REQ-007 CONT  input  1  continuous mode; high = re-arm automatically after each result.
REQ-008 SIG  input  1  signal under measurement, asynchronous to CLK.
REQ-009 FREQ  output  FW  rising-edge count of SIG over the last completed gate (Hz when gate = 1 s).
REQ-010 OVF  output  1  last result saturated.
REQ-011 VALID  output  1  one-cycle pulse, FREQ/OVF updated this cycle.
REQ-012 BUSY  output  1  measurement in progress.

Function
REQ-013 SIG SHALL pass a 2-flop synchronizer plus one history flop; rise = sync2 & ~sync3 (pin-to-rise latency 2-3 CLK).
REQ-014 FSM states SHALL be IDLE, GATE, DONE; encoding free.
REQ-015 IDLE -> GATE at the edge where START=1 or CONT=1; gate counter and event counter cleared on that edge.
REQ-016 GATE SHALL last exactly CLK_HZ cycles: gate counter counts 0..CLK_HZ-1; at CLK_HZ-1 -> DONE.
REQ-017 Event counter SHALL increment only on cycles in GATE with rise=1; rises in IDLE or DONE are discarded.
REQ-018 Event counter SHALL saturate at 2^FW-1; any rise while saturated sets an internal overflow flag, cleared at gate start.
REQ-019 On the GATE -> DONE edge, FREQ SHALL load the final count (including a rise in the last GATE cycle) and OVF the overflow flag; VALID=1 for the single DONE cycle.
REQ-020 DONE -> GATE (counters cleared) if CONT=1, else DONE -> IDLE; continuous mode thus has one dead cycle per CLK_HZ+1-cycle period.
REQ-021 BUSY SHALL be 1 in GATE and DONE, 0 in IDLE, registered.
REQ-022 START while BUSY=1 SHALL be ignored, not queued; START and CONT both high behaves as CONT.
REQ-023 FREQ and OVF SHALL hold their last value between VALID pulses, including across IDLE.
REQ-024 Deasserting CONT during GATE SHALL let the current gate complete normally, then return to IDLE.
REQ-025 Max measurable rate is CLK_HZ/2 edges per second; faster SIG is undefined but SHALL not hang the FSM.

Reset
REQ-026 RST=0 SHALL immediately force IDLE, FREQ=0, OVF=0, VALID=0, BUSY=0, all counters and synchronizer flops to 0.
REQ-027 Reset mid-gate SHALL abort with no VALID pulse; after RST=1 the block waits in IDLE for START/CONT.
REQ-028 First rising CLK edge after RST release SHALL be able to sample START.

Verification (CLK_HZ=1000 unless stated)
REQ-029 Reset: RST=0 during activity -> FREQ=0, OVF=0, VALID=0, BUSY=0 without a clock edge.
REQ-030 SIG period 10 CLK, one-cycle START -> BUSY high 1001 cycles, single VALID at cycle 1001 after START edge, FREQ=100, OVF=0.
REQ-031 SIG held high (then low) over a gate -> FREQ=0, OVF=0; START pulsed during BUSY -> no extra measurement.
REQ-032 FW=6, SIG period 4 CLK -> FREQ=63, OVF=1; following gate with SIG period 40 -> FREQ=25, OVF=0.
REQ-033 CONT=1, SIG period 10 then period 20 -> VALID every 1001 cycles, FREQ 100 then 50; CONT dropped mid-gate -> one more VALID, then IDLE.
REQ-034 RST=0 at gate cycle 500 then released -> no VALID, BUSY=0, FREQ=0; next START gives correct result.

Source files
------------

// File: rtl/freq_meter_if.sv
// Measurement request/result bundle for freq_meter.
// The design side takes the slave modport; the requester side takes the master modport.
interface freq_meter_if #(
    parameter int FW = 24
);
    logic          START;
    logic          CONT;
    logic          SIG;
    logic [FW-1:0] FREQ;
    logic          OVF;
    logic          VALID;
    logic          BUSY;

    modport master (output START, CONT, SIG, input FREQ, OVF, VALID, BUSY);
    modport slave  (input START, CONT, SIG, output FREQ, OVF, VALID, BUSY);
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of SIG over a CLK_HZ-cycle gate
// and publishes the count, single-shot or continuously re-armed.
module freq_meter #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CW     = 26,
    parameter int FW     = 24
) (
    input  logic         CLK,
    input  logic         RST,
    freq_meter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_t;

    state_t        r_state;
    logic [2:0]    r_sync;
    logic [CW-1:0] r_gcnt;
    logic [FW-1:0] r_ecnt;
    logic          r_ovf_flag;
    logic [FW-1:0] r_freq;
    logic          r_ovf;
    logic          r_valid;
    logic          r_busy;

    logic          w_rise;
    logic          w_sat;
    logic          w_gate_end;
    logic [FW-1:0] w_ecnt_nxt;
    logic          w_ovf_nxt;

    // r_sync[1] is the second synchronizer stage, r_sync[2] its history copy
    assign w_rise     = r_sync[1] & ~r_sync[2];
    assign w_sat      = (r_ecnt == '1);
    assign w_gate_end = (r_gcnt == CW'(CLK_HZ - 1));
    assign w_ecnt_nxt = (w_rise && !w_sat) ? r_ecnt + FW'(1) : r_ecnt;
    assign w_ovf_nxt  = r_ovf_flag | (w_rise & w_sat);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_sync     <= '0;
            r_gcnt     <= '0;
            r_ecnt     <= '0;
            r_ovf_flag <= 1'b0;
            r_freq     <= '0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sync  <= {r_sync[1:0], bus.SIG};
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.START || bus.CONT) begin
                        r_state    <= S_GATE;
                        r_busy     <= 1'b1;
                        r_gcnt     <= '0;
                        r_ecnt     <= '0;
                        r_ovf_flag <= 1'b0;
                    end
                end
                S_GATE: begin
                    r_ecnt     <= w_ecnt_nxt;
                    r_ovf_flag <= w_ovf_nxt;
                    // Result takes the next-count so a rise in the final gate cycle is included
                    if (w_gate_end) begin
                        r_state <= S_DONE;
                        r_freq  <= w_ecnt_nxt;
                        r_ovf   <= w_ovf_nxt;
                        r_valid <= 1'b1;
                    end else begin
                        r_gcnt <= r_gcnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.CONT) begin
                        r_state    <= S_GATE;
                        r_gcnt     <= '0;
                        r_ecnt     <= '0;
                        r_ovf_flag <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.FREQ  = r_freq;
    assign bus.OVF   = r_ovf;
    assign bus.VALID = r_valid;
    assign bus.BUSY  = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: stimulus queues expected results, a monitor checks each VALID.
// Instance A uses FW=24, instance B uses FW=6; both run a 1000-cycle gate.
module tb_freq_meter;

    logic CLK;
    logic RST;

    freq_meter_if #(.FW(24)) ifa ();
    freq_meter_if #(.FW(6))  ifb ();

    freq_meter #(.CLK_HZ(1000), .CW(10), .FW(24)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));
    freq_meter #(.CLK_HZ(1000), .CW(10), .FW(6))  dut_b (.CLK(CLK), .RST(RST), .bus(ifb));

    typedef struct {
        int freq;
        int ovf;
        int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int nvec  = 0;
    int nfail = 0;
    int pcnt  = 0;
    int per   = 10;
    int ph    = 0;
    logic lvl = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) pcnt <= pcnt + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every VALID must match the oldest queued expectation, including its cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (ifa.VALID) begin
            if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_freq",  int'(ifa.FREQ), e.freq);
                chk("a_ovf",   int'(ifa.OVF),  e.ovf);
                chk("a_cycle", pcnt,           e.cyc);
            end
        end
        if (ifb.VALID) begin
            if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_freq",  int'(ifb.FREQ), e.freq);
                chk("b_ovf",   int'(ifb.OVF),  e.ovf);
                chk("b_cycle", pcnt,           e.cyc);
            end
        end
    end

    // Advance to the next falling edge and drive SIG: period `per` (high first half), or `lvl` when per==0.
    task automatic tick();
        logic s;
        @(negedge CLK);
        if (per != 0) begin
            s  = (ph < per / 2);
            ph = (ph + 1 == per) ? 0 : ph + 1;
        end else begin
            s = lvl;
        end
        ifa.SIG = s;
        ifb.SIG = s;
    endtask

    // One-cycle START, a stray START mid-gate that must be ignored, and a BUSY length check.
    task automatic run_shot(input bit onb, input int ef, input int eo);
        int busy;
        exp_t e;
        tick();
        if (onb) ifb.START = 1'b1; else ifa.START = 1'b1;
        e.freq = ef; e.ovf = eo; e.cyc = pcnt + 1001;
        if (onb) qb.push_back(e); else qa.push_back(e);
        busy = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (i == 0 || i == 301) begin
                ifa.START = 1'b0;
                ifb.START = 1'b0;
            end else if (i == 300) begin
                if (onb) ifb.START = 1'b1; else ifa.START = 1'b1;
            end
            busy += onb ? int'(ifb.BUSY) : int'(ifa.BUSY);
        end
        chk(onb ? "b_busy_len" : "a_busy_len", busy, 1001);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        exp_t e;
        RST = 1'b0;
        ifa.START = 1'b0; ifa.CONT = 1'b0; ifa.SIG = 1'b0;
        ifb.START = 1'b0; ifb.CONT = 1'b0; ifb.SIG = 1'b0;
        #1;
        chk("a_rst_freq",  int'(ifa.FREQ),  0);
        chk("a_rst_ovf",   int'(ifa.OVF),   0);
        chk("a_rst_valid", int'(ifa.VALID), 0);
        chk("a_rst_busy",  int'(ifa.BUSY),  0);
        chk("b_rst_freq",  int'(ifb.FREQ),  0);
        chk("b_rst_busy",  int'(ifb.BUSY),  0);
        repeat (5) tick();
        RST = 1'b1;
        repeat (30) tick();

        // Period 10 -> 100 edges per gate
        run_shot(1'b0, 100, 0);
        repeat (5) tick();
        chk("a_freq_hold", int'(ifa.FREQ), 100);

        // SIG constant high, then constant low
        per = 0; lvl = 1'b1; repeat (10) tick();
        run_shot(1'b0, 0, 0);
        lvl = 1'b0; repeat (10) tick();
        run_shot(1'b0, 0, 0);

        // FW=6: 250 edges saturate at 63, then period 40 -> 25 with OVF cleared
        per = 4; ph = 0; repeat (20) tick();
        run_shot(1'b1, 63, 1);
        per = 40; ph = 0; repeat (60) tick();
        run_shot(1'b1, 25, 0);
        chk("a_freq_hold2", int'(ifa.FREQ), 0);

        // Continuous: rises at tick 10m (m<=200), then at 2010+20n; CONT dropped at tick 3500
        per = 0; lvl = 1'b0; repeat (10) tick();
        per = 10; ph = 0;
        tick();
        ifa.CONT = 1'b1;
        c = pcnt;
        e.ovf = 0;
        e.freq = 100; e.cyc = c + 1001; qa.push_back(e);
        e.freq = 100; e.cyc = c + 2002; qa.push_back(e);
        e.freq = 50;  e.cyc = c + 3003; qa.push_back(e);
        e.freq = 50;  e.cyc = c + 4004; qa.push_back(e);
        for (int t = 1; t <= 4100; t++) begin
            if (t == 2010) begin
                per = 20;
                ph  = 0;
            end
            tick();
            if (t == 3500) ifa.CONT = 1'b0;
        end
        chk("a_busy_after_cont", int'(ifa.BUSY), 0);
        chk("a_cont_results_seen", qa.size(), 0);

        // Reset at gate cycle ~500: asynchronous clear, no VALID
        per = 10; ph = 0; repeat (20) tick();
        tick(); ifa.START = 1'b1;
        tick(); ifa.START = 1'b0;
        repeat (499) tick();
        #2;
        RST = 1'b0;
        per = 0; lvl = 1'b0;
        #1;
        chk("a_midrst_freq",  int'(ifa.FREQ),  0);
        chk("a_midrst_ovf",   int'(ifa.OVF),   0);
        chk("a_midrst_valid", int'(ifa.VALID), 0);
        chk("a_midrst_busy",  int'(ifa.BUSY),  0);
        chk("b_midrst_freq",  int'(ifb.FREQ),  0);
        repeat (5) tick();

        // START sampled on the first edge after release; rises at tick 5+10m
        per = 10; ph = 5;
        tick();
        RST = 1'b1;
        ifa.START = 1'b1;
        e.freq = 100; e.ovf = 0; e.cyc = pcnt + 1001;
        qa.push_back(e);
        tick();
        ifa.START = 1'b0;
        chk("a_busy_first_edge", int'(ifa.BUSY), 1);
        repeat (1100) tick();
        chk("a_busy_end", int'(ifa.BUSY), 0);

        repeat (10) tick();
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
